// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed common-anode seven-segment display driver.
//
// A shadow register captures value_i on load_i, so a changing value_i never tears the display.
// A prescaler advances the digit index every REFRESH_DIV cycles. Every output is registered,
// one cycle behind the index, shadow, blank, leading-zero and decimal-point controls.
//
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous reset, active-low
//   load_i       capture value_i into the shadow register
//   value_i      hex value; nibble i drives digit i (digit 0 is the rightmost)
//   lzb_en_i     leading-zero blanking enable
//   blank_i      turn all digits off (the scan keeps running underneath)
//   dp_mask_i    bit i lights the decimal point of digit i
//   seg_o        segments {g,f,e,d,c,b,a}, active-low
//   dp_o         decimal point, active-low
//   an_o         digit anodes, active-low, at most one bit low
//   scan_tick_o  one-cycle pulse after the digit index advances
module seg7_scan_display #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DATA_W      = 4 * NUM_DIGITS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DATA_W-1:0]     value_i,
  input  logic                  lzb_en_i,
  input  logic                  blank_i,
  input  logic [NUM_DIGITS-1:0] dp_mask_i,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  scan_tick_o
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [6:0] SegOff = 7'h7F;

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_W-1:0]     shadow_q, shadow_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  tick_q, tick_d;

  logic                  cnt_tc;
  logic [3:0]            nibble;
  logic                  dp_sel;
  logic [NUM_DIGITS-1:0] an_sel;
  logic                  upper_zero;
  logic                  lz_blank;
  logic [6:0]            hex_seg;

  // Prescaler, digit index and shadow register.
  always_comb begin
    cnt_tc   = (cnt_q == CntW'(REFRESH_DIV - 1));
    cnt_d    = cnt_tc ? '0 : cnt_q + CntW'(1);
    idx_d    = idx_q;
    if (cnt_tc) begin
      idx_d = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
    end
    shadow_d = load_i ? value_i : shadow_q;
    tick_d   = cnt_tc;
  end

  // Select the current digit's nibble, decimal point and anode; in the same pass find whether
  // every nibble from the current digit upwards is zero (leading-zero condition).
  always_comb begin
    nibble     = 4'h0;
    dp_sel     = 1'b0;
    an_sel     = '1;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        nibble    = shadow_q[4*i +: 4];
        dp_sel    = dp_mask_i[i];
        an_sel[i] = 1'b0;
      end
      if ((IdxW'(i) >= idx_q) && (shadow_q[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    // Digit 0 is never blanked so a zero value still shows a single "0".
    lz_blank = lzb_en_i && (idx_q != '0) && upper_zero;
  end

  // Hex to active-low {g,f,e,d,c,b,a}.
  always_comb begin
    hex_seg = SegOff;
    unique case (nibble)
      4'h0: hex_seg = 7'b1000000;
      4'h1: hex_seg = 7'b1111001;
      4'h2: hex_seg = 7'b0100100;
      4'h3: hex_seg = 7'b0110000;
      4'h4: hex_seg = 7'b0011001;
      4'h5: hex_seg = 7'b0010010;
      4'h6: hex_seg = 7'b0000010;
      4'h7: hex_seg = 7'b1111000;
      4'h8: hex_seg = 7'b0000000;
      4'h9: hex_seg = 7'b0010000;
      4'hA: hex_seg = 7'b0001000;
      4'hB: hex_seg = 7'b0000011;
      4'hC: hex_seg = 7'b1000110;
      4'hD: hex_seg = 7'b0100001;
      4'hE: hex_seg = 7'b0000110;
      4'hF: hex_seg = 7'b0001110;
      default: hex_seg = SegOff;
    endcase
  end

  // Output next-state; global blank overrides everything but leaves the scan running.
  always_comb begin
    if (blank_i) begin
      seg_d = SegOff;
      dp_d  = 1'b1;
      an_d  = '1;
    end else begin
      seg_d = lz_blank ? SegOff : hex_seg;
      dp_d  = ~dp_sel;
      an_d  = an_sel;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      seg_q    <= SegOff;
      dp_q     <= 1'b1;
      an_q     <= '1;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      tick_q   <= tick_d;
    end
  end

  assign seg_o       = seg_q;
  assign dp_o        = dp_q;
  assign an_o        = an_q;
  assign scan_tick_o = tick_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display with 4 digits and a 4-cycle refresh. A behavioural model counts
// edges since reset, derives the scan position arithmetically, and predicts every output
// after every edge; directed steps follow the test plan, then a randomized phase runs.
module tb_seg7_scan_display;

  localparam int unsigned N  = 4;
  localparam int unsigned RD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [15:0]   value;
  logic          lzb_en;
  logic          blank;
  logic [N-1:0]  dp_mask;
  logic [6:0]    seg;
  logic          dp;
  logic [N-1:0]  an;
  logic          scan_tick;

  seg7_scan_display #(
    .NUM_DIGITS (N),
    .REFRESH_DIV(RD),
    .DATA_W     (4 * N)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (load),
    .value_i    (value),
    .lzb_en_i   (lzb_en),
    .blank_i    (blank),
    .dp_mask_i  (dp_mask),
    .seg_o      (seg),
    .dp_o       (dp),
    .an_o       (an),
    .scan_tick_o(scan_tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int          m_count;   // edges since the last reset edge
  logic [15:0] m_shadow;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [N-1:0] e_an;
  logic        e_tick;
  logic [6:0]  hex_tab [16];

  initial begin
    hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001;
    hex_tab[2]  = 7'b0100100; hex_tab[3]  = 7'b0110000;
    hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010;
    hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000;
    hex_tab[8]  = 7'b0000000; hex_tab[9]  = 7'b0010000;
    hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
    hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001;
    hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;
  end

  function automatic int cur_idx();
    return (m_count / RD) % N;
  endfunction

  task automatic check_bits(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    int idx;
    int pre;
    logic [15:0] upper;
    @(posedge clk);
    if (!rst_n) begin
      e_seg    = 7'h7F;
      e_dp     = 1'b1;
      e_an     = '1;
      e_tick   = 1'b0;
      m_count  = 0;
      m_shadow = '0;
    end else begin
      idx   = cur_idx();
      pre   = m_count % RD;
      upper = m_shadow >> (4 * idx);
      if (blank) begin
        e_an  = '1;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
      end else begin
        e_an  = ~(N'(1) << idx);
        e_dp  = ~dp_mask[idx];
        e_seg = (lzb_en && idx > 0 && upper == 16'h0) ? 7'h7F : hex_tab[upper[3:0]];
      end
      e_tick  = (pre == RD - 1);
      m_count = m_count + 1;
      if (load) m_shadow = value;
    end
    #1;
    check_bits("seg", {9'h0, seg}, {9'h0, e_seg});
    check_bits("dp", {15'h0, dp}, {15'h0, e_dp});
    check_bits("an", {12'h0, an}, {12'h0, e_an});
    check_bits("scan_tick", {15'h0, scan_tick}, {15'h0, e_tick});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n   = 1'b0;
    load    = 1'b0;
    value   = '0;
    lzb_en  = 1'b0;
    blank   = 1'b0;
    dp_mask = '0;
    m_count = 0;
    m_shadow = '0;

    // Reset state.
    steps(2);
    check_bits("reset_an", {12'h0, an}, 16'h000F);
    check_bits("reset_seg", {9'h0, seg}, 16'h007F);

    // Load 12AF on the first cycle out of reset and watch two full scans.
    #1;
    rst_n = 1'b1;
    load  = 1'b1;
    value = 16'h12AF;
    step();
    load = 1'b0;
    step();
    check_bits("first_digit_F_seg", {9'h0, seg}, 16'h000E);
    check_bits("first_digit_F_an", {12'h0, an}, 16'h000E);
    steps(32);

    // Changing value without load must not disturb the display.
    value = 16'hFFFF;
    steps(16);

    // Leading-zero blanking on and off.
    value  = 16'h0005;
    load   = 1'b1;
    lzb_en = 1'b1;
    step();
    load = 1'b0;
    steps(16);
    lzb_en = 1'b0;
    steps(16);

    // Load landing on the same edge as the terminal count.
    for (int i = 0; i < RD && (m_count % RD) != RD - 1; i++) step();
    value = 16'hFFFF;
    load  = 1'b1;
    step();
    load = 1'b0;
    step();
    check_bits("load_at_tc_shows_F", {9'h0, seg}, 16'h000E);
    steps(8);

    // Global blank for 10 cycles, scan phase preserved.
    value = 16'h12AF;
    load  = 1'b1;
    step();
    load  = 1'b0;
    blank = 1'b1;
    steps(10);
    check_bits("blank_an", {12'h0, an}, 16'h000F);
    blank = 1'b0;
    steps(16);

    // Decimal point on digit 2 only.
    dp_mask = 4'b0100;
    steps(16);
    dp_mask = '0;

    // Reset while digit 2 is being addressed.
    for (int i = 0; i < RD * N && cur_idx() != 2; i++) step();
    rst_n = 1'b0;
    step();
    check_bits("midscan_rst_an", {12'h0, an}, 16'h000F);
    check_bits("midscan_rst_seg", {9'h0, seg}, 16'h007F);
    check_bits("midscan_rst_tick", {15'h0, scan_tick}, 16'h0000);
    rst_n = 1'b1;
    step();
    check_bits("post_rst_digit0_zero", {9'h0, seg}, 16'h0040);
    steps(16);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      load    = ($urandom_range(0, 3) == 0);
      value   = 16'($urandom);
      if ($urandom_range(0, 1) == 0) value[15:8] = '0;
      lzb_en  = ($urandom_range(0, 1) == 1);
      blank   = ($urandom_range(0, 7) == 0);
      dp_mask = N'($urandom);
      rst_n   = ($urandom_range(0, 63) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
Name: seg7_scan_display

Overview:
Parametrised, time-multiplexed seven-segment display driver. It is the successor to the single-digit R15 decoder.
- Latches a multi-nibble value into a shadow register on a load strobe.
- Scans NUM_DIGITS common-anode digits at a programmable refresh rate.
- Adds leading-zero blanking, per-digit decimal points and global blanking.
- Sits at top level between the datapath (R15 and other debug values) and the board's seg/an pins.

Parameters:
- NUM_DIGITS, 4: digits scanned. Range 1..8.
- REFRESH_DIV, 100000: clk cycles each digit stays lit. Minimum 1.
- DATA_W, 4*NUM_DIGITS: width of value. Must equal 4*NUM_DIGITS.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low. Sampled on the rising clk edge.
- load  input  1  when 1, capture value into the shadow register.
- value  input  DATA_W  hex value to display. Nibble i drives digit i; digit 0 is the rightmost.
- lzb_en  input  1  leading-zero blanking enable.
- blank  input  1  when 1, all digits off.
- dp_mask  input  NUM_DIGITS  bit i = 1 lights the decimal point of digit i.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- an  output  NUM_DIGITS  digit anodes, active-low, at most one bit low.
- scan_tick  output  1  one-cycle pulse when the digit index advances.

Behaviour:
- Reset (rst=0 at an edge), applied at the next edge regardless of state, including mid-scan:
  - prescaler=0, digit_idx=0, shadow=0.
  - seg=7'h7F, dp=1, an=all 1s, scan_tick=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - At terminal count: digit_idx <= (digit_idx+1) mod NUM_DIGITS, and scan_tick=1 on the following cycle only.
  - With REFRESH_DIV=1, the index advances every cycle.
- Shadow:
  - load=1 at an edge sets shadow <= value. Otherwise shadow holds.
  - value changes without load have no effect, so the display never tears.
- Outputs:
  - All registered, with 1-cycle latency from digit_idx, shadow, blank, lzb_en and dp_mask.
  - Load and index advance on the same edge: both take effect. The newly selected digit shows the new shadow one cycle later.
- Digit select:
  - an[digit_idx]=0, all other an bits 1.
  - dp = ~dp_mask[digit_idx].
- Hex encoding of nibble n = shadow[4*digit_idx +: 4]:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking (lzb_en=1):
  - Digit i>0 is blanked when nibbles i..NUM_DIGITS-1 are all zero. A blanked digit has seg=7'h7F; dp still follows dp_mask.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Global blank (blank=1):
  - an=all 1s, seg=7'h7F, dp=1.
  - Prescaler and digit_idx keep running, so the scan phase is preserved when blank drops.
- Wrap-around: digit_idx goes NUM_DIGITS-1 -> 0. There is no idle or stall state.
- NUM_DIGITS=1: an is constant 0 after reset; scan_tick still pulses every REFRESH_DIV cycles.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=4.
  - Stimulus: release reset; load=1 with value=16'h12AF for one cycle.
  - Required response:
    - an sequence 1110, 1101, 1011, 0111, each held 4 cycles, then wraps to 1110.
    - seg for digits 0..3 = 0001110, 0001000, 0100100, 1111001.
    - scan_tick pulses every 4 cycles.
- Leading-zero blanking:
  - Stimulus: load value=16'h0005, lzb_en=1.
  - Required response: digit 0 seg=0010010; digits 1..3 seg=1111111 with their an still scanning.
  - Stimulus: lzb_en=0.
  - Required response: digits 1..3 seg=1000000.
- Tearing and simultaneous events:
  - Stimulus: change value to 16'hFFFF with load=0.
  - Required response: display unchanged.
  - Stimulus: assert load on the same edge as the terminal count.
  - Required response: the new digit shows F on the next cycle.
- Blank and decimal points:
  - Stimulus: blank=1 for 10 cycles, then release.
  - Required response: an=1111 throughout; scan resumes at the index reached, with no restart from digit 0.
  - Stimulus: dp_mask=4'b0100.
  - Required response: dp=0 only while an=1011.
- Reset mid-scan:
  - Stimulus: rst=0 for one edge while digit_idx=2 and shadow=16'h12AF.
  - Required response:
    - Next cycle: an=1111, seg=1111111, scan_tick=0.
    - After release: digit 0 shows "0" and shadow=0.
